// File: rtl/pc_interface_initiator.sv
// Host-side initiator: sends one command byte over a UART byte stream, then streams bank write data
// or reassembles bank read data. Optional RX stall abort is enabled by defining RX_TIMEOUT_EN.
module pc_interface_initiator #(
    parameter int TEST_PATTERN_WIDTH = 56,
    parameter int TIMEOUT_WIDTH      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_rdy,
    input  logic [3:0]                    i_req_addr,
    input  logic                          i_req_wr,
    input  logic                          i_req_inc,
    input  logic [TEST_PATTERN_WIDTH-1:0] i_wdata,
    output logic                          o_wdata_rd,
    output logic [TEST_PATTERN_WIDTH-1:0] o_rdata,
    output logic                          o_rdata_valid,
    output logic [2:0]                    o_rdata_addr,
    output logic                          o_done,
    output logic                          o_error,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_wr,
    input  logic                          i_tx_rdy,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_valid,
    output logic                          o_rx_rd
);

    localparam int PATTERN_BYTES = (TEST_PATTERN_WIDTH + 7) / 8;
    localparam int SW            = PATTERN_BYTES * 8;
    localparam int CW            = $clog2(PATTERN_BYTES);

    typedef enum logic [3:0] {
        IDLE, CMD, LOAD, TX_WAIT, TX, RX_WAIT, RX, RDONE, NEXT, DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0]                    addr;
    logic                          wr;
    logic                          inc;
    logic [CW-1:0]                 cnt;
    logic [SW-1:0]                 tx_sr;
    logic [SW-9:0]                 rx_sr;
    logic                          tx_wr_q;
    logic [7:0]                    tx_data_q;
    logic [TEST_PATTERN_WIDTH-1:0] rdata_q;
    logic [2:0]                    rdata_addr_q;
    logic                          timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        o_req_rdy     = 1'b0;
        o_wdata_rd    = 1'b0;
        o_rx_rd       = 1'b0;
        o_rdata_valid = 1'b0;
        o_done        = 1'b0;
        o_error       = 1'b0;
        case (state)
            IDLE: begin
                o_req_rdy = 1'b1;
                if (i_req_valid) state_nx = CMD;
            end
            CMD:     if (i_tx_rdy) state_nx = LOAD;
            LOAD: begin
                o_wdata_rd = wr;
                state_nx   = wr ? TX_WAIT : RX_WAIT;
            end
            TX_WAIT: if (i_tx_rdy) state_nx = TX;
            TX:      state_nx = (cnt == '0) ? NEXT : TX_WAIT;
            RX_WAIT: begin
                if (i_rx_valid) begin
                    state_nx = RX;
                end else if (timeout) begin
                    o_error  = 1'b1;
                    state_nx = IDLE;
                end
            end
            RX: begin
                o_rx_rd  = 1'b1;
                state_nx = (cnt == '0) ? RDONE : RX_WAIT;
            end
            RDONE: begin
                o_rdata_valid = 1'b1;
                state_nx      = NEXT;
            end
            NEXT:    state_nx = (inc && addr[2:0] != 3'd7) ? LOAD : DONE;
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The TX strobe is registered one state early (on leaving CMD / TX_WAIT) so that it is high
    // exactly in the cycle after the ready check, carrying the byte that state would send.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr         <= '0;
            wr           <= 1'b0;
            inc          <= 1'b0;
            cnt          <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            tx_wr_q      <= 1'b0;
            tx_data_q    <= '0;
            rdata_q      <= '0;
            rdata_addr_q <= '0;
        end else begin
            tx_wr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        addr <= i_req_addr;
                        wr   <= i_req_wr;
                        inc  <= i_req_inc;
                    end
                end
                CMD: begin
                    if (i_tx_rdy) begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= {2'b00, wr, inc, addr};
                    end
                end
                LOAD: begin
                    cnt   <= addr[3] ? CW'(PATTERN_BYTES - 1) : CW'(1);
                    rx_sr <= '0;
                    if (wr) begin
                        if (addr[3]) tx_sr <= SW'(i_wdata);
                        else         tx_sr <= {i_wdata[15:0], {(SW-16){1'b0}}};
                    end
                end
                TX_WAIT: begin
                    if (i_tx_rdy) begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= tx_sr[SW-1 -: 8];
                    end
                end
                TX: begin
                    tx_sr <= tx_sr << 8;
                    cnt   <= cnt - 1'b1;
                end
                RX: begin
                    rx_sr <= {rx_sr[SW-17:0], i_rx_data};
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        rdata_q      <= TEST_PATTERN_WIDTH'({rx_sr, i_rx_data});
                        rdata_addr_q <= addr[2:0];
                    end
                end
                NEXT: begin
                    if (inc && addr[2:0] != 3'd7) addr[2:0] <= addr[2:0] + 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef RX_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] to_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || state == LOAD || state == RX) to_cnt <= '0;
        else if (state == RX_WAIT && !(&to_cnt))   to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = &to_cnt;
`else
    // RX_WAIT never gives up; the width parameter stays referenced for interface compatibility.
    assign timeout = 1'b0 & (TIMEOUT_WIDTH > 0);
`endif

    assign o_tx_wr      = tx_wr_q;
    assign o_tx_data    = tx_data_q;
    assign o_rdata      = rdata_q;
    assign o_rdata_addr = rdata_addr_q;

endmodule

// File: tb/tb_pc_interface_initiator.sv
// Scoreboard bench for pc_interface_initiator: a byte-level reference model fills expectation queues,
// an independent monitor pops and compares on every TX strobe, read completion, done and error pulse.
module tb_pc_interface_initiator;

    localparam int TPW = 56;
    localparam int PB  = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_rdy;
    logic [3:0]     req_addr = '0;
    logic           req_wr = 1'b0;
    logic           req_inc = 1'b0;
    logic [TPW-1:0] wdata = '0;
    logic           wdata_rd;
    logic [TPW-1:0] rdata;
    logic           rdata_valid;
    logic [2:0]     rdata_addr;
    logic           done;
    logic           error;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic           tx_rdy = 1'b1;
    logic [7:0]     rx_data = '0;
    logic           rx_valid = 1'b0;
    logic           rx_rd;

    pc_interface_initiator #(.TEST_PATTERN_WIDTH(TPW), .TIMEOUT_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_rdy(req_rdy),
        .i_req_addr(req_addr), .i_req_wr(req_wr), .i_req_inc(req_inc),
        .i_wdata(wdata), .o_wdata_rd(wdata_rd),
        .o_rdata(rdata), .o_rdata_valid(rdata_valid), .o_rdata_addr(rdata_addr),
        .o_done(done), .o_error(error),
        .o_tx_data(tx_data), .o_tx_wr(tx_wr), .i_tx_rdy(tx_rdy),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_rd(rx_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TPW-1:0] data;
        logic [2:0]     addr;
    } rd_t;

    int errors = 0;
    int checks = 0;
    byte unsigned   exp_tx[$];
    rd_t            exp_rd[$];
    byte unsigned   rxq[$];
    logic [TPW-1:0] bank_w[8];
    byte unsigned   rx_bytes[64];
    int widx = 0;
    int done_pending = 0;
    int err_pending = 0;
    int done_seen = 0;
    int err_seen = 0;
    int tx_in_req = 0;
    int tx_pct = 100;
    int rx_pct = 100;
    int cyc = 0;
    int rx_cyc = 0;
    int err_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    initial begin : monitor
        logic prev_wr;
        rd_t  r;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wr = 1'b0;
            end else begin
                if (tx_wr) begin
                    check("tx_spacing", 64'(prev_wr), 0);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got byte %0h with nothing expected", tx_data);
                    end else begin
                        check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                    end
                    tx_in_req++;
                end
                prev_wr = tx_wr;
                if (rx_rd) rx_cyc = cyc;
                if (rdata_valid) begin
                    if (exp_rd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_extra: got %0h at %0d with nothing expected", rdata, rdata_addr);
                    end else begin
                        r = exp_rd.pop_front();
                        check("rdata", 64'(rdata), 64'(r.data));
                        check("rdata_addr", 64'(rdata_addr), 64'(r.addr));
                    end
                end
                if (done) begin
                    done_seen++;
                    check("done_expected", 64'(done_pending > 0), 1);
                    if (done_pending > 0) done_pending--;
                    check("done_tx_left", 64'(exp_tx.size()), 0);
                    check("done_rd_left", 64'(exp_rd.size()), 0);
                end
                if (error) begin
                    err_seen++;
                    err_cyc = cyc;
                    check("error_expected", 64'(err_pending > 0), 1);
                    if (err_pending > 0) err_pending--;
                end
            end
        end
    end

    // Input driver: TX FIFO readiness, FWFT RX FIFO and the write-data source
    initial begin : driver
        bit rd_pend;
        forever begin
            @(negedge clk);
            if (wdata_rd) begin
                wdata = bank_w[widx % 8];
                widx++;
            end
            rd_pend = rx_rd;
            @(posedge clk);
            #1;
            if (rd_pend && !rst && rxq.size() > 0) void'(rxq.pop_front());
            wdata    = TPW'({$urandom(), $urandom()});
            tx_rdy   = ($urandom_range(99) < tx_pct);
            rx_valid = (rxq.size() > 0) && ($urandom_range(99) < rx_pct);
            rx_data  = (rxq.size() > 0) ? rxq[0] : 8'($urandom());
        end
    end

    task automatic issue(input logic [3:0] a, input bit w, input bit i);
        for (int t = 0; t < 50 && !req_rdy; t++) @(negedge clk);
        check("req_rdy_before_issue", 64'(req_rdy), 1);
        req_addr  = a;
        req_wr    = w;
        req_inc   = i;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 4'($urandom());
        req_wr    = 1'($urandom());
        req_inc   = 1'($urandom());
    endtask

    // Reference model: command byte, per-bank byte sequence and reassembled read values.
    task automatic do_req(input logic [3:0] a, input bit w, input bit i, input int abort_at);
        int nb, bn;
        logic [TPW-1:0] val;
        byte unsigned b;
        nb = i ? 8 - int'(a[2:0]) : 1;
        bn = a[3] ? PB : 2;
        exp_tx.push_back({2'b00, w, i, a});
        for (int k = 0; k < nb; k++) begin
            if (w) begin
                for (int j = 0; j < bn; j++) begin
                    if (a[3]) b = 8'(bank_w[k] >> (8 * (bn - 1 - j)));
                    else      b = 8'(bank_w[k][15:0] >> (8 * (1 - j)));
                    exp_tx.push_back(b);
                end
            end else begin
                val = '0;
                for (int j = 0; j < bn; j++) begin
                    b = rx_bytes[k * bn + j];
                    rxq.push_back(b);
                    val = {val[TPW-9:0], b};
                end
                exp_rd.push_back('{data: val, addr: 3'(int'(a[2:0]) + k)});
            end
        end
        widx      = 0;
        tx_in_req = 0;
        done_pending++;
        issue(a, w, i);
        if (abort_at > 0) begin
            for (int t = 0; t < 500 && tx_in_req < abort_at; t++) @(negedge clk);
            check("bytes_before_abort", 64'(tx_in_req >= abort_at), 1);
            rst = 1'b1;
            exp_tx.delete();
            done_pending = 0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("abort_strobes", 64'({tx_wr, rx_rd, wdata_rd, rdata_valid, done, error}), 0);
            check("abort_rdy", 64'(req_rdy), 1);
            begin
                int ds;
                ds = done_seen;
                repeat (30) @(negedge clk);
                check("abort_no_done", 64'(done_seen - ds), 0);
            end
            check("abort_idle_rdy", 64'(req_rdy), 1);
        end else begin
            for (int t = 0; t < 5000 && done_pending > 0; t++) @(posedge clk);
            check("done_within_budget", 64'(done_pending), 0);
            if (w) check("wdata_rd_count", 64'(widx), 64'(nb));
            else   check("rx_left", 64'(rxq.size()), 0);
        end
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 8; k++) bank_w[k] = TPW'({$urandom(), $urandom()});
        for (int k = 0; k < 64; k++) rx_bytes[k] = 8'($urandom());
    endtask

    initial begin : watchdog
        #800000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdy", 64'(req_rdy), 1);
        check("reset_strobes", 64'({tx_wr, rx_rd, wdata_rd, rdata_valid, done, error}), 0);
        check("reset_tx_data", 64'(tx_data), 0);
        check("reset_rdata", 64'(rdata), 0);
        check("reset_rdata_addr", 64'(rdata_addr), 0);

        // Write P bank, no increment
        randomize_data();
        bank_w[0] = 56'h00112233445566;
        do_req(4'h9, 1'b1, 1'b0, 0);

        // Write CS banks 2..7; upper write-data bits must be ignored
        randomize_data();
        for (int k = 0; k < 8; k++) bank_w[k] = {bank_w[k][TPW-1:16], 16'hA5C3};
        do_req(4'h2, 1'b1, 1'b1, 0);

        // Read P bank 0
        randomize_data();
        rx_bytes[0] = 8'hDE; rx_bytes[1] = 8'hAD; rx_bytes[2] = 8'hBE; rx_bytes[3] = 8'hEF;
        rx_bytes[4] = 8'h01; rx_bytes[5] = 8'h02; rx_bytes[6] = 8'h03;
        do_req(4'h8, 1'b0, 1'b0, 0);

        // Read CS banks 6 and 7 with increment
        randomize_data();
        rx_bytes[0] = 8'h12; rx_bytes[1] = 8'h34; rx_bytes[2] = 8'h56; rx_bytes[3] = 8'h78;
        do_req(4'h6, 1'b0, 1'b1, 0);

        // Randomized requests under FIFO back-pressure
        for (int n = 0; n < 30; n++) begin
            randomize_data();
            tx_pct = $urandom_range(30, 100);
            rx_pct = $urandom_range(80, 100);
            do_req(4'($urandom()), 1'($urandom()), 1'($urandom()), 0);
        end

        // Reset in the middle of a P write after the third TX byte
        randomize_data();
        tx_pct = 50;
        do_req(4'hB, 1'b1, 1'b0, 3);

        // Recovery after the abort
        randomize_data();
        tx_pct = 70;
        do_req(4'hD, 1'b1, 1'b1, 0);

`ifdef RX_TIMEOUT_EN
        // CS read with only one byte available: aborts through the RX timeout
        tx_pct = 100;
        rx_pct = 100;
        begin
            int es;
            es = err_seen;
            exp_tx.push_back(8'h03);
            rxq.push_back(8'h5A);
            err_pending = 1;
            issue(4'h3, 1'b0, 1'b0);
            for (int t = 0; t < 200 && err_seen == es; t++) @(posedge clk);
            check("timeout_error_seen", 64'(err_seen - es), 1);
            check("timeout_latency", 64'(err_cyc - rx_cyc), 16);
            @(negedge clk);
            check("timeout_idle_rdy", 64'(req_rdy), 1);
            check("timeout_tx_left", 64'(exp_tx.size()), 0);
        end
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
